mem_req_issue: RTL

//  Parametrised data-side memory access unit between EXE and MEM. Issues load/store requests on an

---
 rtl/mem_req_issue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_req_issue.sv
// Data-side memory access unit: issues SRAM-like load/store requests,
// tracks outstanding accesses in order and returns aligned load results.
module mem_req_issue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 5,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = (DATA_W == 64) ? 3 : 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wr,
    input  logic [1:0]        in_size,
    input  logic              in_sext,
    input  logic [31:0]       in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              in_ale,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [NB-1:0]     data_wstrb,
    output logic [31:0]       data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              resp_valid,
    output logic              resp_wr,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [CNT_W-1:0]  outstanding,
    output logic              proto_err
);

    logic              ale;
    logic [OFF_W-1:0]  off_in;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  drop_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              q_wr   [DEPTH];
    logic [1:0]        q_size [DEPTH];
    logic              q_sext [DEPTH];
    logic [OFF_W-1:0]  q_off  [DEPTH];
    logic [TAG_W-1:0]  q_tag  [DEPTH];

    logic              h_wr;
    logic [1:0]        h_size;
    logic              h_sext;
    logic [OFF_W-1:0]  h_off;
    logic [TAG_W-1:0]  h_tag;

    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] msk;
    logic              sb;
    logic [DATA_W-1:0] ld_data;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        nxt = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        unique case (in_size)
            2'd0:    ale = 1'b0;
            2'd1:    ale = in_addr[0];
            2'd2:    ale = |in_addr[1:0];
            default: ale = |in_addr[2:0];
        endcase
    end

    assign off_in   = in_addr[OFF_W-1:0];
    assign data_req = in_valid & ~ale & ~flush & (count < CNT_W'(DEPTH));
    assign in_ready = in_valid & (ale | (data_req & data_addr_ok));
    assign in_ale   = in_valid & ale;
    assign data_wr   = in_wr;
    assign data_size = in_size;
    assign data_addr = in_addr;

    // Strobes cover [off, off+2^size); store data is replicated per lane.
    always_comb begin
        data_wstrb = '0;
        data_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            data_wstrb[i] = (i >= int'(off_in)) &&
                            (i < int'(off_in) + (1 << int'(in_size)));
            data_wdata[8*i +: 8] = in_wdata[8*(i % (1 << int'(in_size))) +: 8];
        end
    end

    assign push = data_req & data_addr_ok;
    assign pop  = data_data_ok & (count != '0);

    assign h_wr   = q_wr[rd_ptr];
    assign h_size = q_size[rd_ptr];
    assign h_sext = q_sext[rd_ptr];
    assign h_off  = q_off[rd_ptr];
    assign h_tag  = q_tag[rd_ptr];

    always_comb begin
        sh = data_rdata >> {h_off, 3'b000};
        unique case (h_size)
            2'd0:    msk = DATA_W'(8'hFF);
            2'd1:    msk = DATA_W'(16'hFFFF);
            2'd2:    msk = DATA_W'(32'hFFFF_FFFF);
            default: msk = '1;
        endcase
        unique case (h_size)
            2'd0:    sb = sh[7];
            2'd1:    sb = sh[15];
            2'd2:    sb = sh[31];
            default: sb = 1'b0;
        endcase
        ld_data = (sh & msk) | ((h_sext & sb) ? ~msk : '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[wr_ptr]   <= in_wr;
            q_size[wr_ptr] <= in_size;
            q_sext[wr_ptr] <= in_sext;
            q_off[wr_ptr]  <= off_in;
            q_tag[wr_ptr]  <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_cnt   <= '0;
            proto_err  <= 1'b0;
            resp_valid <= 1'b0;
            resp_wr    <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (data_data_ok && count == '0) proto_err <= 1'b1;
            // Flush marks every surviving entry as dropped.
            if (flush) drop_cnt <= count - CNT_W'(pop);
            else if (pop && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            resp_valid <= 1'b0;
            if (pop && drop_cnt == '0 && !flush) begin
                resp_valid <= 1'b1;
                resp_wr    <= h_wr;
                resp_data  <= h_wr ? '0 : ld_data;
                resp_tag   <= h_tag;
            end
        end
    end

    assign outstanding = count - drop_cnt;

endmodule
